// File: rtl/decode_stage_if.sv
// Fetch-side and register-read-side handshake bundle for the decode stage.
// The stage itself uses the slave view; its environment uses the master view.
interface decode_stage_if #(
  parameter int IW  = 9,
  parameter int OPW = 5,
  parameter int RW  = 3,
  parameter int DW  = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [IW-1:0]  mach_code;
  logic           out_valid;
  logic           out_ready;
  logic [OPW-1:0] opcode;
  logic [RW-1:0]  reg1;
  logic [RW-1:0]  reg2;
  logic [DW-1:0]  immediate;

  modport master (
    output in_valid, mach_code, out_ready,
    input  in_ready, out_valid, opcode, reg1, reg2, immediate
  );

  modport slave (
    input  in_valid, mach_code, out_ready,
    output in_ready, out_valid, opcode, reg1, reg2, immediate
  );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction decoder with an in-stream mode toggle and a
// run-time programmable immediate table; one word per handshake, latency 1.
module decode_stage #(
  parameter int                IW    = 9,
  parameter int                OPW   = 5,
  parameter int                RW    = 3,
  parameter int                DW    = 8,
  parameter logic [OPW-1:0]    SW_RR = '1,
  parameter logic [IW-2*RW-1:0] SW_RI = '1
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus,
  input  logic          flush,
  output logic          mode,
  input  logic          imm_we,
  input  logic [RW-1:0] imm_waddr,
  input  logic [DW-1:0] imm_wdata
);

  localparam int F     = (IW - OPW) / 2;
  localparam int DEPTH = 1 << RW;

  function automatic logic [DW-1:0] table_init(input int idx);
    case (idx)
      1:       return DW'(1);
      2:       return DW'(4);
      3:       return DW'(8);
      4:       return DW'(16);
      5:       return DW'(32);
      6:       return DW'(64);
      7:       return DW'(127);
      default: return '0;
    endcase
  endfunction

  logic           out_valid_q, out_valid_d;
  logic           mode_q, mode_d;
  logic [OPW-1:0] opcode_q, opcode_d;
  logic [RW-1:0]  reg1_q, reg1_d;
  logic [RW-1:0]  reg2_q, reg2_d;
  logic [DW-1:0]  immediate_q, immediate_d;
  logic [DW-1:0]  table_q [DEPTH];
  logic [DW-1:0]  table_d [DEPTH];

  logic           in_ready;
  logic           accept;
  logic           dec_switch;
  logic [OPW-1:0] dec_op;
  logic [RW-1:0]  dec_r1;
  logic [RW-1:0]  dec_r2;
  logic [DW-1:0]  dec_imm;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !flush;

  // Field extraction depends only on the current mode; the table read uses
  // the pre-edge contents so a same-cycle write is not visible yet.
  always_comb begin
    dec_op     = '0;
    dec_r1     = '0;
    dec_r2     = '0;
    dec_imm    = '0;
    dec_switch = 1'b0;
    if (mode_q) begin
      dec_op     = OPW'(bus.mach_code[IW-1:2*RW]);
      dec_r1     = bus.mach_code[2*RW-1:RW];
      dec_r2     = bus.mach_code[RW-1:0];
      dec_imm    = table_q[bus.mach_code[RW-1:0]];
      dec_switch = (bus.mach_code[IW-1:2*RW] == SW_RI);
    end else begin
      dec_op     = bus.mach_code[IW-1 -: OPW];
      dec_r1     = RW'(bus.mach_code[2*F-1:F]);
      dec_r2     = RW'(bus.mach_code[F-1:0]);
      dec_switch = (bus.mach_code[IW-1 -: OPW] == SW_RR);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    mode_d      = mode_q;
    opcode_d    = opcode_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    immediate_d = immediate_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept && !dec_switch) begin
      out_valid_d = 1'b1;
      opcode_d    = dec_op;
      reg1_d      = dec_r1;
      reg2_d      = dec_r2;
      immediate_d = dec_imm;
    end else begin
      // A switch word is swallowed; a pending pop still retires the output.
      if (accept) mode_d = !mode_q;
      if (bus.out_ready) out_valid_d = 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
      assign table_d[gi] = (imm_we && imm_waddr == RW'(gi)) ? imm_wdata : table_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      mode_q      <= 1'b0;
      opcode_q    <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      immediate_q <= '0;
      for (int i = 0; i < DEPTH; i++) table_q[i] <= table_init(i);
    end else begin
      out_valid_q <= out_valid_d;
      mode_q      <= mode_d;
      opcode_q    <= opcode_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      immediate_q <= immediate_d;
      table_q     <= table_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.opcode    = opcode_q;
  assign bus.reg1      = reg1_q;
  assign bus.reg2      = reg2_q;
  assign bus.immediate = immediate_q;
  assign mode          = mode_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized checks of decode_stage against a field-arithmetic
// reference model; one line per transaction.
module tb_decode_stage;
  localparam int IW  = 9;
  localparam int OPW = 5;
  localparam int RW  = 3;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush;
  logic          mode;
  logic          imm_we;
  logic [RW-1:0] imm_waddr;
  logic [DW-1:0] imm_wdata;

  always #5 clk = ~clk;

  decode_stage_if #(.IW(IW), .OPW(OPW), .RW(RW), .DW(DW)) bif ();

  decode_stage #(.IW(IW), .OPW(OPW), .RW(RW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bif.slave),
    .flush     (flush),
    .mode      (mode),
    .imm_we    (imm_we),
    .imm_waddr (imm_waddr),
    .imm_wdata (imm_wdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int tbl [8];
  bit m_mode;
  bit m_valid;
  int m_op, m_r1, m_r2, m_imm;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    tbl = '{0, 1, 4, 8, 16, 32, 64, 127};
    m_mode  = 1'b0;
    m_valid = 1'b0;
    m_op = 0; m_r1 = 0; m_r2 = 0; m_imm = 0;
  endfunction

  function automatic void model_step(input bit inv, input int code, input bit ordy,
                                     input bit fl, input bit we, input int wa, input int wd);
    bit ready;
    bit sw;
    int op, r1, r2, imm;
    ready = !m_valid || ordy;
    if (!m_mode) begin
      op = code / 16; r1 = (code / 4) % 4; r2 = code % 4; imm = 0;
      sw = (op == 31);
    end else begin
      op = code / 64; r1 = (code / 8) % 8; r2 = code % 8; imm = tbl[r2];
      sw = (op == 7);
    end
    if (fl) begin
      m_valid = 1'b0;
    end else if (inv && ready) begin
      if (sw) begin
        m_mode  = !m_mode;
        m_valid = m_valid && !ordy;
      end else begin
        m_valid = 1'b1;
        m_op = op; m_r1 = r1; m_r2 = r2; m_imm = imm;
      end
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    if (we) tbl[wa] = wd;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".out_valid"}, bif.out_valid, m_valid);
    check({tag, ".mode"},      mode,          m_mode);
    check({tag, ".opcode"},    bif.opcode,    m_op);
    check({tag, ".reg1"},      bif.reg1,      m_r1);
    check({tag, ".reg2"},      bif.reg2,      m_r2);
    check({tag, ".immediate"}, bif.immediate, m_imm);
  endtask

  // Called at posedge+1; leaves the bench at the next posedge+1.
  task automatic step(input bit inv, input int code, input bit ordy, input bit fl,
                      input bit we, input int wa, input int wd);
    bif.in_valid  = inv;
    bif.mach_code = code[IW-1:0];
    bif.out_ready = ordy;
    flush         = fl;
    imm_we        = we;
    imm_waddr     = wa[RW-1:0];
    imm_wdata     = wd[DW-1:0];
    #2;
    check("in_ready", bif.in_ready, (!m_valid || ordy));
    @(posedge clk);
    model_step(inv, code, ordy, fl, we, wa, wd);
    #1;
    compare_all("step");
    $display("txn t=%0t v=%0b code=%03h rdy=%0b fl=%0b we=%0b -> ov=%0b mode=%0b op=%0d r1=%0d r2=%0d imm=%0d",
             $time, inv, code, ordy, fl, we, bif.out_valid, mode, bif.opcode, bif.reg1,
             bif.reg2, bif.immediate);
  endtask

  task automatic idle_inputs();
    bif.in_valid = 1'b0; bif.mach_code = '0; bif.out_ready = 1'b0;
    flush = 1'b0; imm_we = 1'b0; imm_waddr = '0; imm_wdata = '0;
  endtask

  initial begin
    bit inv, ordy, fl, we;
    int code;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic reg-reg decode
    step(1, 9'b001101101, 1, 0, 0, 0, 0);
    check("rr.opcode", bif.opcode, 6);
    check("rr.reg1", bif.reg1, 3);
    check("rr.reg2", bif.reg2, 1);
    check("rr.imm", bif.immediate, 0);

    // switch to reg-imm, decode, switch back
    step(1, 9'b111110000, 1, 0, 0, 0, 0);
    check("sw_rr.valid", bif.out_valid, 0);
    check("sw_rr.mode", mode, 1);
    step(1, 9'b010011101, 1, 0, 0, 0, 0);
    check("ri.opcode", bif.opcode, 2);
    check("ri.reg1", bif.reg1, 3);
    check("ri.reg2", bif.reg2, 5);
    check("ri.imm", bif.immediate, 32);
    step(1, 9'b111000000, 1, 0, 0, 0, 0);
    check("sw_ri.mode", mode, 0);
    check("sw_ri.valid", bif.out_valid, 0);

    // backpressure hold
    step(1, 9'b000100110, 0, 0, 0, 0, 0);
    step(1, 9'b010001011, 0, 0, 0, 0, 0);
    check("hold.opcode", bif.opcode, 2);
    check("hold.reg2", bif.reg2, 2);
    step(1, 9'b010001011, 1, 0, 0, 0, 0);
    check("release.opcode", bif.opcode, 8);
    check("release.reg1", bif.reg1, 2);
    step(0, 0, 1, 0, 0, 0, 0);
    check("drain.valid", bif.out_valid, 0);

    // table read-before-write
    step(1, 9'b111110000, 1, 0, 0, 0, 0);
    step(1, 9'b001000111, 1, 0, 1, 7, 200);
    check("rbw.old", bif.immediate, 127);
    step(1, 9'b001000111, 1, 0, 0, 0, 0);
    check("rbw.new", bif.immediate, 200);

    // flush drops the output and incoming words, including switch words
    step(1, 9'b000001010, 0, 0, 0, 0, 0);
    step(1, 9'b000011011, 1, 1, 0, 0, 0);
    check("flush.valid", bif.out_valid, 0);
    step(1, 9'b111000000, 1, 1, 0, 0, 0);
    check("flush_sw.mode", mode, 1);

    // asynchronous reset mid-operation
    step(1, 9'b000000001, 0, 0, 1, 2, 99);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 9'b111110000, 1, 0, 0, 0, 0);
    step(1, 9'b000000010, 1, 0, 0, 0, 0);
    check("rst_table.imm", bif.immediate, 4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      inv  = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 4) < 3);
      fl   = ($urandom_range(0, 19) == 0);
      we   = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 4) == 0)
        code = m_mode ? (448 + $urandom_range(0, 63)) : (496 + $urandom_range(0, 15));
      else
        code = $urandom_range(0, 511);
      step(inv, code, ordy, fl, we, $urandom_range(0, 7), $urandom_range(0, 255));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
